// File: rtl/bcd_display_ctrl.sv
// Serial double-dabble binary-to-BCD converter feeding a 4-digit common-anode
// seven-segment scanner with optional leading-zero blanking and overflow dashes.
//
// state | meaning
// IDLE  | value_ready high, waiting for a handshake
// SHIFT | one add-3/shift step per clock, 16 steps total
// DONE  | latch result and overflow, pulse done next cycle
module bcd_display_ctrl #(
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        value_valid,
  input  logic [15:0] value,
  output logic        value_ready,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_shreg;
  logic [19:0]   r_acc;
  logic [3:0]    r_bitcnt;
  logic          r_done;
  logic [15:0]   r_bcd;
  logic          r_ovf;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;

  logic [19:0]   w_adj;
  logic          w_accept;
  logic          w_ovf;
  logic [3:0]    w_digit_val;
  logic          w_blank;
  logic [6:0]    w_seg_dec;

  assign value_ready = (r_state == S_IDLE);
  assign w_accept    = value_valid && (r_state == S_IDLE);
  assign done        = r_done;
  assign bcd_out     = r_bcd;
  assign overflow    = r_ovf;

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 5; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  // A fifth BCD digit or any out-of-range low digit means the reading exceeds 9999.
  assign w_ovf = (r_acc[19:16] != 4'd0) || (r_acc[15:12] > 4'd9) ||
                 (r_acc[11:8] > 4'd9) || (r_acc[7:4] > 4'd9) || (r_acc[3:0] > 4'd9);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: if (r_bitcnt == 4'd15) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg  <= '0;
      r_acc    <= '0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shreg  <= value;
            r_acc    <= '0;
            r_bitcnt <= '0;
          end
        end
        S_SHIFT: begin
          r_acc    <= {w_adj[18:0], r_shreg[15]};
          r_shreg  <= {r_shreg[14:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        S_DONE: begin
          r_bcd  <= r_acc[15:0];
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= 2'd0;
    end else if (r_scan_cnt == SCAN_MAX) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_digit_val = r_bcd[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_blank = 1'b0;
    if (BLANK_LEADING) begin
      case (r_digit)
        2'd1:    w_blank = (r_bcd[15:4] == 12'd0);
        2'd2:    w_blank = (r_bcd[15:8] == 8'd0);
        2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
        default: w_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_seg_dec = 7'b1111111;
    case (w_digit_val)
      4'd0: w_seg_dec = 7'b1000000;
      4'd1: w_seg_dec = 7'b1111001;
      4'd2: w_seg_dec = 7'b0100100;
      4'd3: w_seg_dec = 7'b0110000;
      4'd4: w_seg_dec = 7'b0011001;
      4'd5: w_seg_dec = 7'b0010010;
      4'd6: w_seg_dec = 7'b0000010;
      4'd7: w_seg_dec = 7'b1111000;
      4'd8: w_seg_dec = 7'b0000000;
      4'd9: w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

  assign an  = ~(4'b0001 << r_digit);
  assign seg = r_ovf   ? 7'b0111111 :
               w_blank ? 7'b1111111 : w_seg_dec;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed-plus-random bench for bcd_display_ctrl; two instances share stimulus,
// one with leading-zero blanking and one without.
module tb_bcd_display_ctrl;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        value_valid = 1'b0;
  logic [15:0] value = '0;

  logic        value_ready, done, overflow;
  logic [15:0] bcd_out;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        nb_ready, nb_done, nb_overflow;
  logic [15:0] nb_bcd;
  logic [3:0]  nb_an;
  logic [6:0]  nb_seg;

  int n_assert = 0;
  int n_fail   = 0;
  int n_edge   = 0;
  int rst_edge = 0;
  int exp_shown = 0;

  bcd_display_ctrl #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .value_valid(value_valid), .value(value),
    .value_ready(value_ready), .done(done), .bcd_out(bcd_out),
    .overflow(overflow), .an(an), .seg(seg));

  bcd_display_ctrl #(.SCAN_DIV(SD), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .value_valid(value_valid), .value(value),
    .value_ready(nb_ready), .done(nb_done), .bcd_out(nb_bcd),
    .overflow(nb_overflow), .an(nb_an), .seg(nb_seg));

  always #5 clk = ~clk;

  // Edge bookkeeping so the expected scan position is elapsed time since reset.
  always @(posedge clk) begin
    n_edge <= n_edge + 1;
    if (rst) rst_edge <= n_edge + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    int m;
    m = v % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (v > 9999) return 7'b0111111;
    if (blank && idx > 0 && v < p) return 7'b1111111;
    return seg_of((v / p) % 10);
  endfunction

  task automatic check_display();
    int k;
    int idx;
    logic [3:0] ea;
    k   = n_edge - rst_edge;
    idx = (k / SD) % 4;
    ea  = 4'b0001 << idx;
    ea  = ~ea;
    chk("an", an, ea);
    chk("seg", seg, exp_seg(exp_shown, idx, 1'b1));
    chk("an_noblank", nb_an, ea);
    chk("seg_noblank", nb_seg, exp_seg(exp_shown, idx, 1'b0));
  endtask

  task automatic scan_check(input int n);
    repeat (n) begin
      @(negedge clk);
      check_display();
    end
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic wait_done(input int v, input int chg_at, input logic [15:0] chg_val,
                           input bit tail);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got = 1;
        exp_shown = v;
      end else begin
        chk("bcd_stable", bcd_out, bcd_of(exp_shown));
      end
      check_display();
      if (lat == chg_at) value = chg_val;
    end
    chk("done_latency", lat, 17);
    chk("bcd_out", bcd_out, bcd_of(v));
    chk("overflow", overflow, (v > 9999));
    chk("nb_bcd_out", nb_bcd, bcd_of(v));
    chk("ready_in_done", value_ready, 1);
    if (tail) begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      check_display();
    end
  endtask

  task automatic convert(input int v);
    chk("ready_idle", value_ready, 1);
    value_valid = 1'b1;
    value = 16'(v);
    @(negedge clk);
    value_valid = 1'b0;
    value = 16'($urandom);
    chk("ready_busy", value_ready, 0);
    wait_done(v, -1, '0, 1'b1);
  endtask

  initial begin
    int sv [3];
    int acc_e;
    int prev_e;
    int v;
    sv[0] = 5; sv[1] = 42; sv[2] = 305;
    prev_e = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", value_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    check_display();

    convert(1234);
    scan_check(20);
    convert(0);
    scan_check(16);
    convert(7);
    scan_check(16);
    convert(9999);
    scan_check(8);
    convert(10000);
    scan_check(16);
    convert(65535);
    scan_check(4);

    value_valid = 1'b1;
    value = 16'(sv[0]);
    for (int i = 0; i < 3; i++) begin
      chk("stream_ready", value_ready, 1);
      acc_e = n_edge + 1;
      if (i > 0) chk("stream_gap", acc_e - prev_e, 18);
      prev_e = acc_e;
      @(negedge clk);
      chk("stream_busy", value_ready, 0);
      chk("stream_done_low", done, 0);
      value = 16'($urandom);
      if (i < 2) wait_done(sv[i], 6, 16'(sv[i+1]), 1'b0);
      else begin
        value_valid = 1'b0;
        wait_done(sv[i], -1, '0, 1'b1);
      end
    end

    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 1) ? int'($urandom_range(65535, 0)) : int'($urandom_range(9999, 0));
      scan_check(int'($urandom_range(3, 0)));
      convert(v);
    end

    convert(1234);
    value_valid = 1'b1;
    value = 16'd4321;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("pre_abort_bcd", bcd_out, 16'h1234);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_shown = 0;
    chk("abort_ready", value_ready, 1);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", overflow, 0);
    check_display();
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      check_display();
    end
    convert(4321);
    scan_check(8);

    convert(56);
    scan_check(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_display_ctrl.md
# bcd_display_ctrl

Sequential binary-to-BCD conversion and 4-digit seven-segment scan controller. It accepts 16-bit sensor readings over a valid/ready handshake and converts them serially with shift-add-3 (double dabble), one bit per clock. It latches the result and time-multiplexes four digits onto a common-anode display with leading-zero blanking. It sits between the measurement logic and the board display pins.

## Interface

- SCAN_DIV, 50000, clock cycles each digit is driven (≥2)
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all four digits
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- value_valid  in  1  source offers value this cycle
- value  in  16  unsigned binary reading
- value_ready  out  1  high in IDLE; transfer when value_valid && value_ready
- done  out  1  one-cycle pulse when bcd_out/overflow update
- bcd_out  out  16  latched result {thousands, hundreds, tens, ones}, 4 bits each
- overflow  out  1  latched: last accepted value > 9999
- an  out  4  digit enables, active-low, one-hot-zero
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation

- Reset: synchronous and active-high; the clock is clk and the reset is rst. Reset forces converter to IDLE, bcd_out=0, overflow=0, done=0, scan counter=0, digit index=0.
- Converter FSM states:
  - IDLE: value_ready=1. On handshake, load value into a 16-bit shift register, clear a 20-bit BCD accumulator (5 digits), clear a 4-bit bit counter, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator digit ≥5, then shift {acc, shreg} left by 1 with MSB of value first. After the 16th shift, go to DONE.
  - DONE: bcd_out <= acc[15:0], overflow <= (acc[19:16]!=0) || any of acc digits 3..0 invalid (cannot occur), done <= 1, then go to IDLE.
- value_valid outside IDLE is ignored. The source holds value_valid and value until accepted.
- bcd_out and overflow are stable between done pulses. The display always shows the latched result, never intermediate accumulator contents.
- Scan: a divider counts 0..SCAN_DIV-1. On wrap, digit index increments mod 4 (0=ones…3=thousands). an[idx]=0 and the other bits are 1.
- Segment encoding for BCD 0–9 uses standard active-low patterns, e.g. 0=1000000, 1=1111001, 4=0011001, 8=0000000.
- Blanking, when BLANK_LEADING=1: a digit is blanked (seg=1111111) if it and every higher digit are zero. The ones digit is never blanked.
- Overflow display: every digit shows a dash, seg=0111111. Blanking does not apply.

## Timing

- A handshake at edge E0 puts the converter in SHIFT for edges E1..E16. DONE is active in the cycle after E16. At edge E17, bcd_out, overflow and done update and the state returns to IDLE.
- done is high exactly during the cycle after E17. value_ready is high in that same cycle, so back-to-back accepts occur every 18 cycles.
- Latency from handshake to valid result is 17 clocks.
- Reset asserted mid-conversion aborts the conversion; the next cycle is IDLE with bcd_out=0. Reset takes priority over a simultaneous handshake.
- After reset: value_ready=1, done=0, an=1110, seg=1000000 ("0" on ones digit; other digits are not enabled).
- The digit changes exactly every SCAN_DIV cycles. The first switch (to tens) is at the SCAN_DIV-th edge after reset release. The scan is free-running and independent of the converter.
- an and seg are registered or derived from registered state only; they have no combinational path from value.

## Test plan

- Reset, then value=1234 with valid for one cycle: value_ready drops. After 17 clocks, done pulses once, bcd_out=0x1234, overflow=0. With SCAN_DIV=4, an cycles 1110→1101→1011→0111 every 4 clocks and seg shows 4,3,2,1.
- value=0 then value=7 (BLANK_LEADING=1): bcd_out=0x0000 then 0x0007. Digits 1–3 show 1111111 and the ones digit shows 0 (1000000) then 7 (1111000).
- value=9999 → bcd_out=0x9999, overflow=0. value=10000 → overflow=1 and all digits show 0111111. value=65535 → overflow=1.
- value_valid held high continuously with values 5, 42, 305: accepts occur 18 cycles apart and bcd_out sequence is 0x0005, 0x0042, 0x0305. Value changes while busy are ignored.
- Assert rst on the 8th SHIFT cycle of value=4321: no done pulse, bcd_out=0, value_ready=1 in the next cycle. A following conversion of 4321 yields 0x4321.
- BLANK_LEADING=0 with value=56: display shows 0,0,5,6 on thousands..ones with no blanked digits.
